// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM states and
// word/byte geometry used by the loader and its word assembler.
package instr_mem_loader_pkg;

  localparam int WORD_NUM_DEF   = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; the first byte of a word
// ends up in bits [31:24].
module word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  // word_o already includes the byte being pushed, so the completed word can
  // be captured on the same edge that accepts the fourth byte.
  assign word_o = {shift_q, byte_i};
  assign full_o = push_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (push_i) begin
      shift_d = word_o[23:0];
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program image from a byte stream into instruction memory, one
// 32-bit word per write strobe, holding the CPU while the load runs.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int WORD_NUM = WORD_NUM_DEF,
  parameter int LEN_W    = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic             wr_en_o,
  output logic [31:0]      wr_addr_o,
  output logic [31:0]      wr_data_o,
  output logic             busy_o,
  output logic             cpu_hold_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [31:0] WORD_NUM_U = 32'(WORD_NUM);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             err_q, err_d;

  logic             transfer;
  logic             len_ok;
  logic             asm_clear;
  logic             asm_full;
  logic [31:0]      asm_word;

  assign transfer = byte_valid_i && (state_q == LOAD);
  assign len_ok   = (len_i != '0) && (32'(len_i) <= WORD_NUM_U);

  word_assembler u_word_assembler (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .clear_i (asm_clear),
    .push_i  (transfer),
    .byte_i  (byte_i),
    .word_o  (asm_word),
    .full_o  (asm_full)
  );

  // Any start_i that does not begin a load is reported; outside IDLE it is
  // otherwise ignored so a running load is never disturbed.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;
    asm_clear  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_ok) begin
            len_d      = len_i;
            word_idx_d = '0;
            asm_clear  = 1'b1;
            state_d    = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        err_d = start_i;
        if (asm_full) begin
          wr_addr_d = 32'({word_idx_q, 2'b00});
          wr_data_d = asm_word;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        err_d = start_i;
        if (word_idx_q + LEN_W'(1) == len_q) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + LEN_W'(1);
          state_d    = LOAD;
        end
      end
      DONE: begin
        err_d   = start_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
    end
  end

  assign byte_ready_o = (state_q == LOAD);
  assign wr_en_o      = (state_q == WRITE);
  assign done_o       = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign cpu_hold_o   = busy_o;
  assign err_o        = err_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: expected writes are queued as
// words are driven and matched against every wr_en_o strobe.
module tb_instr_mem_loader;

  localparam int LEN_W = 6;

  logic             clk;
  logic             rstN;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       byteData;
  logic             byteValid;
  logic             byteReady;
  logic             wrEn;
  logic [31:0]      wrAddr;
  logic [31:0]      wrData;
  logic             busy;
  logic             cpuHold;
  logic             done;
  logic             err;

  int vectors     = 0;
  int miscompares = 0;
  int wrCount     = 0;
  int spuriousWr  = 0;
  logic [63:0] expQ[$];

  instr_mem_loader #(.WORD_NUM(32), .LEN_W(LEN_W)) dut (
    .clk_i        (clk),
    .rst_i        (rstN),
    .start_i      (start),
    .len_i        (len),
    .byte_i       (byteData),
    .byte_valid_i (byteValid),
    .byte_ready_o (byteReady),
    .wr_en_o      (wrEn),
    .wr_addr_o    (wrAddr),
    .wr_data_o    (wrData),
    .busy_o       (busy),
    .cpu_hold_o   (cpuHold),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Every write strobe is matched in order against the scoreboard.
  always @(negedge clk) begin
    if (wrEn === 1'b1) begin
      wrCount++;
      if (expQ.size() == 0) begin
        spuriousWr++;
      end else begin
        logic [63:0] exp;
        exp = expQ.pop_front();
        checkOutput("wrAddr", 64'(wrAddr), 64'(exp[63:32]));
        checkOutput("wrData", 64'(wrData), 64'(exp[31:0]));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start pulse was sampled.
  task automatic applyStimulus(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic sendByte(input logic [7:0] b);
    int guard;
    guard     = 0;
    byteData  = b;
    byteValid = 1'b1;
    while (byteReady !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("byteReadyTimeout", 64'(byteReady), 64'd1);
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] addr, input logic [31:0] data, input bit gap);
    expQ.push_back({addr, data});
    for (int i = 0; i < 4; i++) begin
      sendByte(data[31-8*i -: 8]);
      if (gap && i < 3) begin
        checkOutput("readyInGap", 64'(byteReady), 64'd1);
        @(negedge clk);
      end
    end
  endtask

  // Entered at the negedge right after the last byte was accepted.
  task automatic finishLoad(input logic [31:0] lastAddr);
    checkOutput("wrEnAfterLast", 64'(wrEn), 64'd1);
    checkOutput("doneEarly", 64'(done), 64'd0);
    @(negedge clk);
    checkOutput("donePulse", 64'({done, busy, cpuHold}), 64'b111);
    checkOutput("addrHold", 64'(wrAddr), 64'(lastAddr));
    @(negedge clk);
    checkOutput("idleAfterDone", 64'({done, busy, cpuHold, wrEn}), 64'b0);
  endtask

  initial begin
    int wrBase;
    rstN = 1'b0; start = 1'b0; len = '0; byteData = '0; byteValid = 1'b0;
    #1;
    checkOutput("resetOutputs",
                {byteReady, wrEn, busy, cpuHold, done, err, 26'd0, wrAddr ^ wrData},
                64'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] test 1: two-word load");
    wrBase = wrCount;
    applyStimulus(6'd2);
    checkOutput("busyAfterStart", 64'({busy, cpuHold, err}), 64'b110);
    sendWord(32'h0, 32'h20010005, 1'b0);
    sendWord(32'h4, 32'h8C220004, 1'b0);
    finishLoad(32'h4);
    checkOutput("t1Writes", 64'(wrCount - wrBase), 64'd2);

    $display("[TB] test 2: gapped byte stream");
    wrBase = wrCount;
    applyStimulus(6'd2);
    sendWord(32'h0, 32'h20010005, 1'b1);
    sendWord(32'h4, 32'h8C220004, 1'b1);
    finishLoad(32'h4);
    checkOutput("t2Writes", 64'(wrCount - wrBase), 64'd2);

    $display("[TB] test 3: rejected lengths");
    wrBase = wrCount;
    applyStimulus(6'd0);
    checkOutput("errLen0", 64'({err, busy}), 64'b10);
    @(negedge clk);
    checkOutput("errLen0Clear", 64'({err, busy}), 64'b00);
    applyStimulus(6'd33);
    checkOutput("errLen33", 64'({err, busy}), 64'b10);
    @(negedge clk);
    checkOutput("errLen33Clear", 64'({err, busy}), 64'b00);
    checkOutput("t3Writes", 64'(wrCount - wrBase), 64'd0);

    $display("[TB] test 4: start during load");
    wrBase = wrCount;
    applyStimulus(6'd1);
    checkOutput("t4Start", 64'({err, busy}), 64'b01);
    expQ.push_back({32'h0, 32'h11223344});
    sendByte(8'h11);
    sendByte(8'h22);
    applyStimulus(6'd3);
    checkOutput("errMidLoad", 64'({err, busy}), 64'b11);
    sendByte(8'h33);
    checkOutput("errOnePulse", 64'(err), 64'd0);
    sendByte(8'h44);
    finishLoad(32'h0);
    checkOutput("t4Writes", 64'(wrCount - wrBase), 64'd1);

    $display("[TB] test 5: reset mid-word");
    wrBase = wrCount;
    applyStimulus(6'd1);
    sendByte(8'hAA);
    sendByte(8'hBB);
    #1 rstN = 1'b0;
    #1;
    checkOutput("asyncReset",
                {byteReady, wrEn, busy, cpuHold, done, err, 26'd0, wrAddr | wrData},
                64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    applyStimulus(6'd1);
    sendWord(32'h0, 32'hDEADBEEF, 1'b0);
    finishLoad(32'h0);
    checkOutput("t5Writes", 64'(wrCount - wrBase), 64'd1);

    $display("[TB] test 6: full-depth load");
    wrBase = wrCount;
    applyStimulus(6'd32);
    for (int k = 0; k < 32; k++) sendWord(32'(k * 4), 32'(k), 1'b0);
    finishLoad(32'h7C);
    checkOutput("lastData", 64'(wrData), 64'h1F);
    checkOutput("t6Writes", 64'(wrCount - wrBase), 64'd32);

    checkOutput("spuriousWrites", 64'(spuriousWr), 64'd0);
    checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
